// File: rtl/switch_allocator.sv
// Packet-level round-robin output allocator: one IDLE/BUSY FSM per crossbar output.
// Optional grant watchdog enabled by defining SW_ALLOC_TIMEOUT_EN.
module switch_allocator #(
  parameter int PORTS        = 5,
  parameter int CHANNEL_BITS = 3,
  parameter int TIMEOUT      = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PORTS-1:0]              sw_req,
  input  logic [PORTS*CHANNEL_BITS-1:0] sw_chnl,
  output logic [PORTS-1:0]              sw_gnt,
  output logic [PORTS*CHANNEL_BITS-1:0] xbar_sel,
  output logic [PORTS-1:0]              xbar_en,
  output logic [PORTS-1:0]              bad_chnl,
  output logic [PORTS-1:0]              timeout
);
  localparam int CB = CHANNEL_BITS;

  if (PORTS > 2**CHANNEL_BITS || TIMEOUT < 1) begin : g_cfg_check
    $error("switch_allocator: PORTS exceeds channel index range or TIMEOUT < 1");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state   [PORTS];
  logic [CB-1:0]    owner   [PORTS];
  logic [CB-1:0]    ptr     [PORTS];
  logic [CB-1:0]    win     [PORTS];
  logic [CB-1:0]    ptr_nxt [PORTS];
  logic [PORTS-1:0] found, release_o, bad_now, bad_seen, gnt_nxt;

`ifdef SW_ALLOC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0]    hold_cnt [PORTS];
  logic [PORTS-1:0] blocked  [PORTS];
  logic [PORTS-1:0] expire;
`endif

  always_comb begin
    for (int i = 0; i < PORTS; i++)
      bad_now[i] = sw_req[i] && (int'(sw_chnl[i*CB +: CB]) >= PORTS);
  end

  // Round-robin search from ptr[o] with wrap; granted inputs never compete.
  always_comb begin
    gnt_nxt = sw_gnt;
    for (int o = 0; o < PORTS; o++) begin
      found[o]     = 1'b0;
      win[o]       = '0;
      ptr_nxt[o]   = ptr[o];
      release_o[o] = (state[o] == BUSY) && !sw_req[owner[o]];
`ifdef SW_ALLOC_TIMEOUT_EN
      expire[o] = (state[o] == BUSY) && sw_req[owner[o]] && (hold_cnt[o] == CW'(TIMEOUT));
`endif
      for (int k = 0; k < PORTS; k++) begin
        int idx;
        idx = (int'(ptr[o]) + k) % PORTS;
        if (!found[o] && sw_req[idx] && !sw_gnt[idx] &&
`ifdef SW_ALLOC_TIMEOUT_EN
            !blocked[o][idx] &&
`endif
            (int'(sw_chnl[idx*CB +: CB]) == o)) begin
          found[o]   = 1'b1;
          win[o]     = CB'(idx);
          ptr_nxt[o] = CB'((idx + 1) % PORTS);
        end
      end
      if (state[o] == IDLE && found[o]) gnt_nxt[win[o]] = 1'b1;
`ifdef SW_ALLOC_TIMEOUT_EN
      if (release_o[o] || expire[o]) gnt_nxt[owner[o]] = 1'b0;
`else
      if (release_o[o]) gnt_nxt[owner[o]] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < PORTS; o++) begin
        state[o] <= IDLE;
        owner[o] <= '0;
        ptr[o]   <= '0;
`ifdef SW_ALLOC_TIMEOUT_EN
        hold_cnt[o] <= '0;
        blocked[o]  <= '0;
`endif
      end
      sw_gnt   <= '0;
      xbar_en  <= '0;
      xbar_sel <= '0;
      bad_chnl <= '0;
      bad_seen <= '0;
`ifdef SW_ALLOC_TIMEOUT_EN
      timeout  <= '0;
`endif
    end else begin
      sw_gnt   <= gnt_nxt;
      bad_chnl <= bad_now & ~bad_seen;
      bad_seen <= (bad_seen | bad_now) & sw_req;
`ifdef SW_ALLOC_TIMEOUT_EN
      timeout  <= '0;
`endif
      for (int o = 0; o < PORTS; o++) begin
        case (state[o])
          IDLE: begin
            if (found[o]) begin
              state[o]              <= BUSY;
              owner[o]              <= win[o];
              ptr[o]                <= ptr_nxt[o];
              xbar_en[o]            <= 1'b1;
              xbar_sel[o*CB +: CB]  <= win[o];
`ifdef SW_ALLOC_TIMEOUT_EN
              hold_cnt[o]           <= '0;
`endif
            end
          end
          BUSY: begin
`ifdef SW_ALLOC_TIMEOUT_EN
            if (release_o[o] || expire[o]) begin
              state[o]   <= IDLE;
              xbar_en[o] <= 1'b0;
              timeout[o] <= expire[o];
            end else begin
              hold_cnt[o] <= hold_cnt[o] + 1'b1;
            end
`else
            if (release_o[o]) begin
              state[o]   <= IDLE;
              xbar_en[o] <= 1'b0;
            end
`endif
          end
          default: state[o] <= IDLE;
        endcase
`ifdef SW_ALLOC_TIMEOUT_EN
        // Watchdog-released owner stays locked out until it drops its request.
        for (int i = 0; i < PORTS; i++)
          blocked[o][i] <= (blocked[o][i] | (expire[o] && (int'(owner[o]) == i))) & sw_req[i];
`endif
      end
    end
  end

`ifndef SW_ALLOC_TIMEOUT_EN
  assign timeout = '0;
`endif

endmodule
